// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: shares one single-port RAM between the display fetch
// (one read slot per pixel tick) and a writer, with the display slot always winning.
module vga_fb_arbiter #(
  parameter int DW    = 8,
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int SHIFT = 2,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_oob,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  // One extra bit so a framebuffer that exactly fills the address space still compares correctly.
  localparam logic [AW:0] FB_SIZE = (AW+1)'(FB_W * FB_H);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] disp_addr;
  logic          wr_in_range;
  logic          rd_pend;
  logic          vis_q;

  assign disp_addr   = AW'((32'(y) >> SHIFT) * 32'(FB_W) + (32'(x) >> SHIFT));
  assign wr_in_range = ({1'b0, wr_addr} < FB_SIZE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order in which processes are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Display tick always wins; a write is never granted two cycles running.
  always_comb begin
    // NOTE: every output is given a default first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_nxt = S_IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    wr_oob    = 1'b0;

    if (p_tick) begin
      state_nxt = S_RD;
    end else if (wr_req && (state != S_WR)) begin
      state_nxt = S_WR;
    end

    case (state)
      S_RD: begin
        if (video_on) begin
          mem_en   = 1'b1;
          mem_addr = disp_addr;
        end
      end
      S_WR: begin
        wr_ack = 1'b1;
        if (wr_in_range) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end else begin
          wr_oob = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Read data arrives one clk after the RD slot; a blank fetch yields zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      vis_q     <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      rd_pend   <= (state == S_RD);
      pix_valid <= rd_pend;
      if (state == S_RD) begin
        vis_q <= video_on;
      end
      if (rd_pend) begin
        pix_data <= vis_q ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: behavioural RAM, shadow memory and a pixel scoreboard.
module tb_vga_fb_arbiter;

  localparam int DW   = 8;
  localparam int FB_W = 160;
  localparam int AW   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_tick;
  logic          video_on;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_oob;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  bit            ram_wr  [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  vga_fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .x         (x),
    .y         (y),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_oob    (wr_oob),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 37 + 11);
  endfunction

  function automatic logic [AW-1:0] fb_addr(input int xv, input int yv);
    return AW'((yv / 4) * FB_W + xv / 4);
  endfunction

  // Single-port RAM, 1-clk read latency, read data unchanged during a write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Pixel scoreboard: every strobe must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (sb.size() == 0) begin
        chk("sb.strobe", pix_valid, 1'b0);
      end else begin
        chk("sb.pix", pix_data, sb.pop_front());
      end
    end
  end

  // Drives one p_tick cycle, then returns at mid-point of the resulting RD cycle.
  task automatic fetch(input int xv, input int yv, input logic vis);
    next_cycle();
    p_tick   = 1'b1;
    x        = 10'(xv);
    y        = 10'(yv);
    video_on = vis;
    sb.push_back(vis ? exp_mem[fb_addr(xv, yv)] : '0);
    next_cycle();
    p_tick = 1'b0;
    settle();
    chk("rd.en", mem_en, vis);
    chk("rd.ack", wr_ack, 1'b0);
    if (vis) begin
      chk("rd.we", mem_we, 1'b0);
      chk("rd.addr", mem_addr, fb_addr(xv, yv));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = init_val(i);
    reset    = 1'b1;
    p_tick   = 1'b0;
    video_on = 1'b0;
    x        = '0;
    y        = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset state, even with requests present.
    #3;
    p_tick = 1'b1;
    wr_req = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    chk("rst.en", mem_en, 1'b0);
    chk("rst.we", mem_we, 1'b0);
    chk("rst.ack", wr_ack, 1'b0);
    chk("rst.oob", wr_oob, 1'b0);
    chk("rst.pv", pix_valid, 1'b0);
    chk("rst.pd", pix_data, '0);
    next_cycle();
    p_tick = 1'b0;
    wr_req = 1'b0;
    reset  = 1'b0;
    settle();
    chk("post_rst.en", mem_en, 1'b0);
    next_cycle();
    settle();
    chk("post_rst.en2", mem_en, 1'b0);

    // Display fetch x=8,y=4 and its two-clock latency.
    fetch(8, 4, 1'b1);
    chk("fetch.addr162", mem_addr, 162);
    next_cycle();
    settle();
    chk("fetch.pv_early", pix_valid, 1'b0);
    next_cycle();
    settle();
    chk("fetch.pv", pix_valid, 1'b1);
    chk("fetch.pd", pix_data, exp_mem[162]);
    next_cycle();
    settle();
    chk("fetch.pv_drop", pix_valid, 1'b0);
    chk("fetch.hold", pix_data, exp_mem[162]);

    // Corner address, then a blank fetch.
    repeat (2) next_cycle();
    fetch(639, 479, 1'b1);
    chk("corner.addr", mem_addr, 19199);
    repeat (3) next_cycle();
    fetch(700, 0, 1'b0);
    next_cycle();
    next_cycle();
    settle();
    chk("blank.pv", pix_valid, 1'b1);
    chk("blank.pd", pix_data, '0);

    // Collision: write held across the display slot.
    repeat (2) next_cycle();
    p_tick   = 1'b1;
    x        = 10'd20;
    y        = 10'd0;
    video_on = 1'b1;
    wr_req   = 1'b1;
    wr_addr  = AW'(5);
    wr_data  = 8'hA5;
    sb.push_back(exp_mem[5]);
    settle();
    chk("col.ack0", wr_ack, 1'b0);
    next_cycle();
    p_tick = 1'b0;
    settle();
    chk("col.rd_en", mem_en, 1'b1);
    chk("col.rd_we", mem_we, 1'b0);
    chk("col.rd_ack", wr_ack, 1'b0);
    next_cycle();
    settle();
    chk("col.wr_we", mem_we, 1'b1);
    chk("col.wr_addr", mem_addr, 5);
    chk("col.wr_data", mem_wdata, 8'hA5);
    chk("col.wr_ack", wr_ack, 1'b1);
    chk("col.wr_oob", wr_oob, 1'b0);
    exp_mem[5] = 8'hA5;
    next_cycle();
    wr_req = 1'b0;
    settle();
    chk("col.ack_once", wr_ack, 1'b0);
    next_cycle();
    settle();
    chk("col.ack_none", wr_ack, 1'b0);

    // Back-to-back writes: grants alternate with idle cycles.
    next_cycle();
    wr_req  = 1'b1;
    wr_addr = AW'(10);
    wr_data = 8'h11;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("b2b.ack", wr_ack, (k % 2 == 1));
      chk("b2b.we", mem_we, (k % 2 == 1));
      if (k % 2 == 1) begin
        chk("b2b.addr", mem_addr, wr_addr);
        exp_mem[wr_addr] = wr_data;
      end
      next_cycle();
      if (k % 2 == 1) begin
        wr_addr = wr_addr + 1'b1;
        wr_data = wr_data + 8'h11;
      end
    end
    wr_req = 1'b0;

    // Out-of-range write is acked and dropped; last valid address is written.
    next_cycle();
    wr_req  = 1'b1;
    wr_addr = AW'(19200);
    wr_data = 8'hEE;
    settle();
    next_cycle();
    settle();
    chk("oob.ack", wr_ack, 1'b1);
    chk("oob.oob", wr_oob, 1'b1);
    chk("oob.en", mem_en, 1'b0);
    next_cycle();
    wr_req = 1'b0;
    settle();
    chk("oob.ack_off", wr_ack, 1'b0);
    next_cycle();
    wr_req  = 1'b1;
    wr_addr = AW'(19199);
    wr_data = 8'h5A;
    next_cycle();
    settle();
    chk("edge.ack", wr_ack, 1'b1);
    chk("edge.oob", wr_oob, 1'b0);
    chk("edge.we", mem_we, 1'b1);
    exp_mem[19199] = 8'h5A;
    next_cycle();
    wr_req = 1'b0;

    // Reset asserted mid-write aborts it.
    next_cycle();
    wr_req  = 1'b1;
    wr_addr = AW'(7);
    wr_data = 8'h77;
    next_cycle();
    settle();
    chk("rstwr.ack_pre", wr_ack, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rstwr.en", mem_en, 1'b0);
    chk("rstwr.we", mem_we, 1'b0);
    chk("rstwr.ack", wr_ack, 1'b0);
    chk("rstwr.oob", wr_oob, 1'b0);
    chk("rstwr.addr", mem_addr, '0);
    chk("rstwr.wdata", mem_wdata, '0);
    chk("rstwr.pv", pix_valid, 1'b0);
    chk("rstwr.pd", pix_data, '0);
    next_cycle();
    wr_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    settle();
    chk("rstwr.no_ack1", wr_ack, 1'b0);
    next_cycle();
    settle();
    chk("rstwr.no_ack2", wr_ack, 1'b0);
    next_cycle();
    wr_req = 1'b1;
    settle();
    chk("rewr.ack0", wr_ack, 1'b0);
    next_cycle();
    settle();
    chk("rewr.ack", wr_ack, 1'b1);
    chk("rewr.addr", mem_addr, 7);
    exp_mem[7] = 8'h77;
    next_cycle();
    wr_req = 1'b0;

    // Read back written locations through the display path.
    fetch(20, 0, 1'b1);
    repeat (3) next_cycle();
    fetch(28, 0, 1'b1);
    repeat (3) next_cycle();
    fetch(40, 0, 1'b1);
    repeat (3) next_cycle();
    fetch(48, 0, 1'b1);
    repeat (3) next_cycle();
    fetch(639, 479, 1'b1);

    for (int n = 0; n < 10 && sb.size() != 0; n++) next_cycle();
    settle();
    chk("sb.drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
